// File: rtl/product_accumulator_if.sv
// Handshake bundle for product_accumulator: product input stream and
// frame-total output stream, each with its own valid/ready pair.
interface product_accumulator_if #(
   parameter int ACC_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;

   modport master (
      output in_valid, prod, out_ready,
      input  in_ready, out_valid, acc_out, overflow
   );

   modport slave (
      input  in_valid, prod, out_ready,
      output in_ready, out_valid, acc_out, overflow
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of COUNT 4-bit products and hands the total downstream.
// Optional macro PRODUCT_ACCUMULATOR_SATURATE_EN: clamp to all ones on overflow.
module product_accumulator #(
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   product_accumulator_if.slave   bus
);
   localparam int CNT_W = $clog2(COUNT) + 1;

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_DONE  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W:0]   sum;
   logic             last;

   assign sum  = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, bus.prod};
   assign last = (cnt_q == CNT_W'(COUNT - 1));

   assign bus.in_ready  = (state_q == S_ACCUM);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.acc_out   = acc_q;
   assign bus.overflow  = ovf_q;

   // Next-state: accumulate while collecting, hold then clear once done
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_ACCUM: begin
            if (bus.in_valid) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
               acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
               acc_d = sum[ACC_W-1:0];
`endif
               ovf_d = ovf_q | sum[ACC_W];
               if (last) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_ACCUM;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator.
// Three instances: (8,4) main, (4,2) overflow, (8,1) single-product frames.
module tb_product_accumulator;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   product_accumulator_if #(.ACC_W(8)) a8 ();
   product_accumulator_if #(.ACC_W(4)) a4 ();
   product_accumulator_if #(.ACC_W(8)) c1 ();

   product_accumulator #(.ACC_W(8), .COUNT(4)) u_main (
      .clk(clk), .rst_n(rst_n), .bus(a8.slave)
   );
   product_accumulator #(.ACC_W(4), .COUNT(2)) u_small (
      .clk(clk), .rst_n(rst_n), .bus(a4.slave)
   );
   product_accumulator #(.ACC_W(8), .COUNT(1)) u_one (
      .clk(clk), .rst_n(rst_n), .bus(c1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv8(input logic v, input logic [3:0] p);
      a8.in_valid = v;
      a8.prod     = p;
      step();
   endtask

   task automatic drv4(input logic v, input logic [3:0] p);
      a4.in_valid = v;
      a4.prod     = p;
      step();
   endtask

   task automatic drv1(input logic v, input logic [3:0] p);
      c1.in_valid = v;
      c1.prod     = p;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      checks++;
      if (a8.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_in_ready got %b exp 1", a8.in_ready);
      end
      checks++;
      if (a8.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_out_valid got %b exp 0", a8.out_valid);
      end
      checks++;
      if (a8.acc_out !== 8'd0) begin
         errors++;
         $display("FAIL rst_acc got %0d exp 0", a8.acc_out);
      end
      checks++;
      if (a8.overflow !== 1'b0 || a4.overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_ovf got %b/%b exp 0/0", a8.overflow, a4.overflow);
      end
      checks++;
      if (c1.out_valid !== 1'b0 || a4.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_ov_others got %b/%b exp 0/0", c1.out_valid, a4.out_valid);
      end
   endtask

   task automatic test_frame();
      a8.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv8(1'b1, 4'd9);
         checks++;
         if (a8.out_valid !== 1'b0 || a8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_early%0d got ov=%b ir=%b exp ov=0 ir=1", i, a8.out_valid, a8.in_ready);
         end
      end
      drv8(1'b1, 4'd9);
      checks++;
      if (a8.out_valid !== 1'b1 || a8.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL frame_done got ov=%b ir=%b exp ov=1 ir=0", a8.out_valid, a8.in_ready);
      end
      checks++;
      if (a8.acc_out !== 8'd36 || a8.overflow !== 1'b0) begin
         errors++;
         $display("FAIL frame_sum got %0d ovf=%b exp 36 ovf=0", a8.acc_out, a8.overflow);
      end
      drv8(1'b1, 4'd9);
      checks++;
      if (a8.in_ready !== 1'b1 || a8.out_valid !== 1'b0 || a8.acc_out !== 8'd0) begin
         errors++;
         $display("FAIL frame_bubble got ir=%b ov=%b acc=%0d exp ir=1 ov=0 acc=0", a8.in_ready, a8.out_valid, a8.acc_out);
      end
      drv8(1'b1, 4'd1);
      drv8(1'b1, 4'd2);
      drv8(1'b1, 4'd3);
      drv8(1'b1, 4'd4);
      checks++;
      if (a8.out_valid !== 1'b1 || a8.acc_out !== 8'd10) begin
         errors++;
         $display("FAIL frame_next got ov=%b acc=%0d exp ov=1 acc=10", a8.out_valid, a8.acc_out);
      end
      drv8(1'b0, 4'd0);
   endtask

   task automatic test_gapped();
      logic       v[7];
      logic [3:0] p[7];
      v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      p = '{4'd1, 4'd0, 4'd4, 4'd0, 4'd0, 4'd6, 4'd2};
      for (int i = 0; i < 6; i++) begin
         drv8(v[i], p[i]);
         checks++;
         if (a8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_early%0d got %b exp 0", i, a8.out_valid);
         end
      end
      drv8(v[6], p[6]);
      checks++;
      if (a8.out_valid !== 1'b1 || a8.acc_out !== 8'd13) begin
         errors++;
         $display("FAIL gap_sum got ov=%b acc=%0d exp ov=1 acc=13", a8.out_valid, a8.acc_out);
      end
      drv8(1'b0, 4'd0);
   endtask

   task automatic test_backpressure();
      a8.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drv8(1'b1, 4'd3);
      a8.in_valid = 1'b1;
      a8.prod     = 4'd9;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (a8.out_valid !== 1'b1 || a8.in_ready !== 1'b0 || a8.acc_out !== 8'd12) begin
            errors++;
            $display("FAIL bp_hold%0d got ov=%b ir=%b acc=%0d exp ov=1 ir=0 acc=12", i, a8.out_valid, a8.in_ready, a8.acc_out);
         end
         step();
      end
      a8.out_ready = 1'b1;
      drv8(1'b0, 4'd0);
      checks++;
      if (a8.in_ready !== 1'b1 || a8.out_valid !== 1'b0 || a8.acc_out !== 8'd0) begin
         errors++;
         $display("FAIL bp_release got ir=%b ov=%b acc=%0d exp ir=1 ov=0 acc=0", a8.in_ready, a8.out_valid, a8.acc_out);
      end
   endtask

   task automatic test_overflow();
      logic [3:0] exp_acc;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      exp_acc = 4'd15;
`else
      exp_acc = 4'd2;
`endif
      a4.out_ready = 1'b1;
      drv4(1'b1, 4'd9);
      drv4(1'b1, 4'd9);
      checks++;
      if (a4.out_valid !== 1'b1 || a4.acc_out !== exp_acc || a4.overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sum got ov=%b acc=%0d ovf=%b exp ov=1 acc=%0d ovf=1", a4.out_valid, a4.acc_out, a4.overflow, exp_acc);
      end
      drv4(1'b0, 4'd0);
      drv4(1'b1, 4'd1);
      drv4(1'b1, 4'd1);
      checks++;
      if (a4.out_valid !== 1'b1 || a4.acc_out !== 4'd2 || a4.overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got ov=%b acc=%0d ovf=%b exp ov=1 acc=2 ovf=0", a4.out_valid, a4.acc_out, a4.overflow);
      end
      drv4(1'b0, 4'd0);
   endtask

   task automatic test_reset_mid();
      a8.out_ready = 1'b1;
      drv8(1'b1, 4'd9);
      drv8(1'b1, 4'd9);
      rst_n       = 1'b0;
      a8.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (a8.in_ready !== 1'b1 || a8.acc_out !== 8'd0) begin
         errors++;
         $display("FAIL rmid_clear got ir=%b acc=%0d exp ir=1 acc=0", a8.in_ready, a8.acc_out);
      end
      a8.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drv8(1'b1, 4'd1);
      checks++;
      if (a8.out_valid !== 1'b1 || a8.acc_out !== 8'd4) begin
         errors++;
         $display("FAIL rmid_sum got ov=%b acc=%0d exp ov=1 acc=4", a8.out_valid, a8.acc_out);
      end
      drv8(1'b0, 4'd0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (a8.out_valid !== 1'b0 || a8.in_ready !== 1'b1 || a8.acc_out !== 8'd0) begin
         errors++;
         $display("FAIL rdone got ov=%b ir=%b acc=%0d exp ov=0 ir=1 acc=0", a8.out_valid, a8.in_ready, a8.acc_out);
      end
      a8.out_ready = 1'b1;
   endtask

   task automatic test_count1();
      c1.out_ready = 1'b1;
      drv1(1'b1, 4'd7);
      checks++;
      if (c1.out_valid !== 1'b1 || c1.acc_out !== 8'd7 || c1.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL c1_done got ov=%b acc=%0d ir=%b exp ov=1 acc=7 ir=0", c1.out_valid, c1.acc_out, c1.in_ready);
      end
      drv1(1'b0, 4'd0);
      checks++;
      if (c1.in_ready !== 1'b1 || c1.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL c1_back got ir=%b ov=%b exp ir=1 ov=0", c1.in_ready, c1.out_valid);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      a8.in_valid  = 1'b0;
      a8.prod      = 4'd0;
      a8.out_ready = 1'b1;
      a4.in_valid  = 1'b0;
      a4.prod      = 4'd0;
      a4.out_ready = 1'b1;
      c1.in_valid  = 1'b0;
      c1.prod      = 4'd0;
      c1.out_ready = 1'b1;
      test_reset();
      test_frame();
      test_gapped();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_count1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
